// File: rtl/mac_sequencer.sv
// mac_sequencer: initiator for one 8x8 multiply-accumulate unit.
// Holds a TAPS-entry coefficient bank, streams (sample, coefficient) pairs
// into the MAC, then captures the accumulated dot product and offers it
// downstream with a valid/ready handshake.
module mac_sequencer #(
   parameter int unsigned TAPS = 9,
   parameter int unsigned AW   = 4
) (
   input  logic          Clk,
   input  logic          ResetN,
   input  logic          Start,
   input  logic          CoefWe,
   input  logic [AW-1:0] CoefAddr,
   input  logic [7:0]    CoefData,
   input  logic          SampleValid,
   input  logic [7:0]    SampleData,
   output logic          SampleReady,
   output logic [7:0]    MacX,
   output logic [7:0]    MacY,
   output logic          MacAccumReset,
   input  logic [31:0]   MacLocalReg,
   output logic [31:0]   Result,
   output logic          ResultValid,
   input  logic          ResultReady,
   output logic          Busy
);

   typedef enum logic [2:0] {
      S_IDLE,
      S_CLEAR,
      S_FEED,
      S_DRAIN1,
      S_DRAIN2,
      S_OUT
   } state_t;

   state_t        state;
   state_t        state_next;
   logic [AW-1:0] tap;
   logic [7:0]    coef [TAPS];
   logic          accept;
   logic          last_tap;

   // Handshake qualifiers for the sample stream.
   always_comb begin
      accept   = (state == S_FEED) && SampleValid;
      last_tap = (32'(tap) == TAPS - 1);
   end

   // State register.
   always_ff @(posedge Clk or negedge ResetN) begin
      if (!ResetN) state <= S_IDLE;
      else         state <= state_next;
   end

   // Next-state decode.
   always_comb begin
      state_next = state;
      case (state)
         S_IDLE:   if (Start) state_next = S_CLEAR;
         S_CLEAR:  state_next = S_FEED;
         S_FEED:   if (accept && last_tap) state_next = S_DRAIN1;
         S_DRAIN1: state_next = S_DRAIN2;
         S_DRAIN2: state_next = S_OUT;
         S_OUT:    if (ResultReady) state_next = S_IDLE;
         default:  state_next = S_IDLE;
      endcase
   end

   // Moore outputs decoded from the registered state.
   always_comb begin
      SampleReady   = (state == S_FEED);
      MacAccumReset = (state == S_CLEAR);
      ResultValid   = (state == S_OUT);
      Busy          = (state != S_IDLE);
   end

   // Operand registers, tap counter and result capture; operands return to
   // zero on every cycle without an accepted tap so the accumulator holds.
   always_ff @(posedge Clk or negedge ResetN) begin
      if (!ResetN) begin
         tap    <= '0;
         MacX   <= '0;
         MacY   <= '0;
         Result <= '0;
      end else begin
         MacX <= '0;
         MacY <= '0;
         case (state)
            S_CLEAR: tap <= '0;
            S_FEED: begin
               if (accept) begin
                  MacX <= SampleData;
                  MacY <= coef[tap];
                  tap  <= tap + 1'b1;
               end
            end
            S_DRAIN2: Result <= MacLocalReg;
            default: ;
         endcase
      end
   end

   // Coefficient bank, writable in any state; out-of-range indices dropped.
   always_ff @(posedge Clk or negedge ResetN) begin
      if (!ResetN) begin
         for (int unsigned i = 0; i < TAPS; i++) coef[i] <= '0;
      end else if (CoefWe && (32'(CoefAddr) < TAPS)) begin
         coef[CoefAddr] <= CoefData;
      end
   end

endmodule

// File: doc/mac_sequencer.md
# mac_sequencer

Drives one multiply-accumulate unit (8x8 unsigned multiplier into a 32-bit accumulator) through a complete dot product, acting as the initiator side of the MAC interface. It holds a programmable coefficient bank, pulls one 8-bit sample per tap from an upstream stream, presents (sample, coefficient) pairs on the MAC operand ports and issues the MAC accumulator clear. It then captures the accumulated sum and hands it downstream with a valid/ready handshake. One instance serves one convolution window per run.

## Interface
- TAPS, 9, number of products per dot product (legal 1..16).
- AW, 4, coefficient address width; must satisfy 2^AW >= TAPS.
- Clk  in  1  the single clock; all state updates on its rising edge.
- ResetN  in  1  asynchronous, active-low reset.
- Start  in  1  single-cycle request to begin a run; sampled only in IDLE.
- CoefWe  in  1  coefficient write strobe.
- CoefAddr  in  AW  coefficient index; writes with CoefAddr >= TAPS are ignored.
- CoefData  in  8  unsigned coefficient value.
- SampleValid  in  1  upstream sample available.
- SampleData  in  8  unsigned sample value.
- SampleReady  out  1  sequencer accepts a sample this cycle.
- MacX  out  8  MAC operand x (sample), registered.
- MacY  out  8  MAC operand y (coefficient), registered.
- MacAccumReset  out  1  MAC accumulator clear, registered.
- MacLocalReg  in  32  MAC accumulator value.
- Result  out  32  captured dot product.
- ResultValid  out  1  Result is valid.
- ResultReady  in  1  downstream accepts Result.
- Busy  out  1  high in every state except IDLE.

## Operation
- MAC contract: on each Clk edge, LocalReg <= 0 if AccumReset, else LocalReg + x*y, where x*y is zero-extended to 32 bits. The sequencer drives MacX = MacY = 0 on every cycle with no accepted tap, so the accumulator holds its value.
- States:
  - IDLE: Start=1 -> CLEAR. All other inputs are ignored except coefficient writes.
  - CLEAR: one cycle. MacAccumReset=1, MacX = MacY = 0, tap counter <= 0 -> FEED.
  - FEED: SampleReady=1.
    - Accept = SampleValid & SampleReady. On accept: MacX <= SampleData, MacY <= Coef[tap], tap <= tap+1.
    - No accept: MacX, MacY <= 0.
    - Accept with tap == TAPS-1 -> DRAIN.
  - DRAIN: two cycles with SampleReady=0 and MacX = MacY = 0. At the end of the second cycle, Result <= MacLocalReg -> OUT.
  - OUT: ResultValid=1, Result held. ResultReady=1 -> IDLE, and ResultValid drops the next cycle.
- Start outside IDLE is ignored; it is not queued.
- Coefficient bank: TAPS x 8-bit registers, writable in any state.
  - A write to the index being accepted in the same cycle: the accept uses the old value.
  - Writes to taps not yet consumed in the current run take effect in that run.
- Arithmetic is unsigned. The maximum sum is TAPS*255*255 (585225 for TAPS=9), so the 32-bit result never wraps.

## Timing
- Reset, asynchronous: state=IDLE, tap=0, all coefficients=0, MacX=0, MacY=0, MacAccumReset=0, Result=0, ResultValid=0, SampleReady=0, Busy=0.
- Reset asserted mid-run aborts the run immediately. No partial Result is produced. After release, the next Start gets a fresh CLEAR.
- SampleReady, MacAccumReset, ResultValid and Busy are Moore outputs decoded from registered state.
- Latency with SampleValid held high: ResultValid rises TAPS+3 edges after the edge that samples Start (12 for TAPS=9).
- Every cycle with SampleValid=0 in FEED adds one cycle of latency and does not change the result.
- Minimum run-to-run spacing is TAPS+5 cycles, with ResultReady held high and Start reissued in the first IDLE cycle.
- The last accepted pair is present on MacX/MacY during DRAIN cycle 1. The updated MacLocalReg is sampled during DRAIN cycle 2.

## Test plan
- Coefficients all 1, samples 1..9 continuous, ResultReady=1 -> Result=45, ResultValid high exactly 12 edges after Start, high for 1 cycle.
- Coefficients all 255, samples all 255 -> Result=585225 (0x0008ee09). MacAccumReset pulses exactly once, in the cycle after Start.
- Coefficients 1..9, samples all 2, SampleValid toggled 1/0 each cycle -> Result=90. Nine accepts occur, latency grows by 9 cycles, and MacX=MacY=0 on every stall cycle.
- ResultReady held 0 for 5 cycles in OUT -> Result and ResultValid are stable throughout. A Start pulse during OUT is ignored. After ResultReady=1, the block is in IDLE with Busy=0.
- Coefficient write with CoefAddr=12 (TAPS=9) -> bank unchanged. Write Coef[8]=3 during FEED at tap 2, with other coefficients 1 and samples 1 -> Result=11.
- ResetN pulled low after 4 accepted taps -> all outputs return to 0 asynchronously and coefficients return to 0. The next run with coefficients rewritten to 1 and samples 1 -> Result=9, with no residue from the aborted run.
